// File: rtl/sram_axi_arbiter.sv
// Shares one AXI3 master port between the core's instruction and data SRAM ports.
// Single-beat transfers, one transaction in flight, stall held until all of this cycle's requests finish.
module sram_axi_arbiter #(
    parameter logic [3:0]  INST_ID = 4'd0,
    parameter logic [3:0]  DATA_ID = 4'd1,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_sram_en,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    output logic [DATA_W-1:0] inst_sram_rdata,

    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic [DATA_W-1:0] data_sram_rdata,

    output logic              stallreq_for_axi,

    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,

    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    output logic              rready,

    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,

    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,

    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {
        StIdle,
        StRdAr,
        StRdR,
        StWrAwW,
        StWrB
    } state_e;

    state_e              r_state;
    state_e              w_state_next;

    logic                r_sel_data;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_wstrb;
    logic                r_inst_done;
    logic                r_data_done;
    logic                r_aw_ok;
    logic                r_w_ok;
    logic [DATA_W-1:0]   r_inst_rdata;
    logic [DATA_W-1:0]   r_data_rdata;

    logic                w_req_data;
    logic                w_req_inst;
    logic                w_aw_done;
    logic                w_w_done;
    logic                w_stall;

    assign w_req_data = data_sram_en & ~r_data_done;
    assign w_req_inst = inst_sram_en & ~r_inst_done;
    // Handshake already recorded, or happening this cycle.
    assign w_aw_done  = r_aw_ok | (awvalid & awready);
    assign w_w_done   = r_w_ok | (wvalid & wready);
    assign w_stall    = rst & ((r_state != StIdle) | w_req_data | w_req_inst);

    assign stallreq_for_axi = w_stall;
    assign inst_sram_rdata  = r_inst_rdata;
    assign data_sram_rdata  = r_data_rdata;

    assign arid   = r_sel_data ? DATA_ID : INST_ID;
    assign araddr = r_addr;
    assign awid   = DATA_ID;
    assign awaddr = r_addr;
    assign wdata  = r_wdata;
    assign wstrb  = r_wstrb;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_req_data) begin
                    w_state_next = (data_sram_wen == 4'b0000) ? StRdAr : StWrAwW;
                end else if (w_req_inst) begin
                    w_state_next = StRdAr;
                end
            end
            StRdAr: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_state_next = StRdR;
                end
            end
            StRdR: begin
                rready = 1'b1;
                if (rvalid) begin
                    w_state_next = StIdle;
                end
            end
            StWrAwW: begin
                awvalid = ~r_aw_ok;
                wvalid  = ~r_w_ok;
                if (w_aw_done && w_w_done) begin
                    w_state_next = StWrB;
                end
            end
            StWrB: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sel_data   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_inst_done  <= 1'b0;
            r_data_done  <= 1'b0;
            r_aw_ok      <= 1'b0;
            r_w_ok       <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            if (r_state == StIdle) begin
                if (w_req_data) begin
                    r_sel_data <= 1'b1;
                    r_addr     <= data_sram_addr;
                    r_wdata    <= data_sram_wdata;
                    r_wstrb    <= data_sram_wen;
                end else if (w_req_inst) begin
                    r_sel_data <= 1'b0;
                    r_addr     <= inst_sram_addr;
                end
            end

            if ((r_state == StRdR) && rvalid) begin
                if (r_sel_data) begin
                    r_data_rdata <= rdata;
                    r_data_done  <= 1'b1;
                end else begin
                    r_inst_rdata <= rdata;
                    r_inst_done  <= 1'b1;
                end
            end

            if (r_state == StWrAwW) begin
                if (w_aw_done && w_w_done) begin
                    r_aw_ok <= 1'b0;
                    r_w_ok  <= 1'b0;
                end else begin
                    r_aw_ok <= w_aw_done;
                    r_w_ok  <= w_w_done;
                end
            end

            if ((r_state == StWrB) && bvalid) begin
                r_data_done <= 1'b1;
            end

            // Core advances on any edge without a stall; the next cycle's requests start fresh.
            if (!w_stall) begin
                r_inst_done <= 1'b0;
                r_data_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed bench for sram_axi_arbiter: core stimulus at posedge+1, AXI slave at posedge+2,
// checks at negedge against hand-computed per-cycle vectors.
module tb_sram_axi_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq_for_axi;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int n_checks = 0;
    int n_errors = 0;

    // Slave latencies (cycles of valid/ready seen before responding) and handshake counters.
    int ar_lat = 0;
    int r_lat  = 0;
    int aw_lat = 0;
    int w_lat  = 0;
    int b_lat  = 0;
    int n_ar   = 0;
    int n_aw   = 0;
    int n_w    = 0;
    int n_b    = 0;

    // Expected per-cycle vectors, index 0 = request cycle.
    logic [2:0] fetch_vec [4] = '{3'b001, 3'b101, 3'b011, 3'b000};            // {arvalid,rready,stall}
    logic [2:0] sim_vec   [7] = '{3'b001, 3'b101, 3'b011, 3'b001, 3'b101, 3'b011, 3'b000};
    logic [3:0] wr_vec    [9] = '{4'b0001, 4'b1101, 4'b1001, 4'b1001, 4'b0011,
                                  4'b0011, 4'b0011, 4'b0011, 4'b0000};        // {awvalid,wvalid,bready,stall}
    logic [2:0] bp_vec    [9] = '{3'b001, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101,
                                  3'b011, 3'b000};

    sram_axi_arbiter u_dut (
        .clk              (clk),
        .rst              (rst),
        .inst_sram_en     (inst_sram_en),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_rdata  (inst_sram_rdata),
        .data_sram_en     (data_sram_en),
        .data_sram_wen    (data_sram_wen),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .data_sram_rdata  (data_sram_rdata),
        .stallreq_for_axi (stallreq_for_axi),
        .arid             (arid),
        .araddr           (araddr),
        .arvalid          (arvalid),
        .arready          (arready),
        .rdata            (rdata),
        .rvalid           (rvalid),
        .rready           (rready),
        .awid             (awid),
        .awaddr           (awaddr),
        .awvalid          (awvalid),
        .awready          (awready),
        .wdata            (wdata),
        .wstrb            (wstrb),
        .wvalid           (wvalid),
        .wready           (wready),
        .bvalid           (bvalid),
        .bready           (bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'hBFC0_0000) ? 32'h3C1D_8001 : ~a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // AXI slave model
    initial begin
        int          ar_cnt;
        int          r_cnt;
        int          aw_cnt;
        int          w_cnt;
        int          b_cnt;
        logic        r_pend;
        logic [31:0] r_addr;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        r_pend = 1'b0; r_addr = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            if (!rst) begin
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                r_pend = 1'b0;
            end else begin
                if (rready && r_pend) begin
                    if (r_cnt >= r_lat) begin
                        rvalid = 1'b1;
                        rdata  = mem_word(r_addr);
                        r_pend = 1'b0;
                        r_cnt  = 0;
                    end else begin
                        r_cnt++;
                    end
                end
                if (arvalid) begin
                    if (ar_cnt >= ar_lat) begin
                        arready = 1'b1;
                        r_addr  = araddr;
                        r_pend  = 1'b1;
                        ar_cnt  = 0;
                        n_ar++;
                    end else begin
                        ar_cnt++;
                    end
                end
                if (awvalid) begin
                    if (aw_cnt >= aw_lat) begin
                        awready = 1'b1;
                        aw_cnt  = 0;
                        n_aw++;
                    end else begin
                        aw_cnt++;
                    end
                end
                if (wvalid) begin
                    if (w_cnt >= w_lat) begin
                        wready = 1'b1;
                        w_cnt  = 0;
                        n_w++;
                    end else begin
                        w_cnt++;
                    end
                end
                if (bready) begin
                    if (b_cnt >= b_lat) begin
                        bvalid = 1'b1;
                        b_cnt  = 0;
                        n_b++;
                    end else begin
                        b_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b0;
        inst_sram_en    = 1'b1;
        inst_sram_addr  = 32'hBFC0_0000;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = '0;
        data_sram_wdata = '0;

        // Reset held for two checked cycles with a fetch pending.
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
            check("rst_stall", 32'(stallreq_for_axi), 32'd0);
            check("rst_inst_rdata", inst_sram_rdata, 32'd0);
            check("rst_data_rdata", data_sram_rdata, 32'd0);
            @(posedge clk);
        end
        #1;
        rst = 1'b1;

        // Single fetch, zero-wait slave; this is the request cycle.
        @(negedge clk);
        check("fetch_vec0", 32'({arvalid, rready, stallreq_for_axi}), 32'(fetch_vec[0]));
        for (int i = 1; i < 4; i++) begin
            cycle();
            @(negedge clk);
            check($sformatf("fetch_vec%0d", i), 32'({arvalid, rready, stallreq_for_axi}),
                  32'(fetch_vec[i]));
            if (i == 1) begin
                check("fetch_arid", 32'(arid), 32'd0);
                check("fetch_araddr", araddr, 32'hBFC0_0000);
            end
        end
        check("fetch_rdata", inst_sram_rdata, 32'h3C1D_8001);
        cycle();
        inst_sram_en = 1'b0;
        @(negedge clk);
        check("fetch_release_stall", 32'(stallreq_for_axi), 32'd0);

        // Fetch and load in the same core cycle: data first, then inst.
        cycle();
        inst_sram_en   = 1'b1;
        inst_sram_addr = 32'hBFC0_0100;
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'b0000;
        data_sram_addr = 32'h8000_1000;
        @(negedge clk);
        check("sim_vec0", 32'({arvalid, rready, stallreq_for_axi}), 32'(sim_vec[0]));
        for (int i = 1; i < 7; i++) begin
            cycle();
            @(negedge clk);
            check($sformatf("sim_vec%0d", i), 32'({arvalid, rready, stallreq_for_axi}),
                  32'(sim_vec[i]));
            if (i == 1) begin
                check("sim_data_arid", 32'(arid), 32'd1);
                check("sim_data_araddr", araddr, 32'h8000_1000);
            end
            if (i == 3) begin
                check("sim_mid_data_rdata", data_sram_rdata, 32'h7FFF_EFFF);
                check("sim_mid_inst_rdata", inst_sram_rdata, 32'h3C1D_8001);
            end
            if (i == 4) begin
                check("sim_inst_arid", 32'(arid), 32'd0);
                check("sim_inst_araddr", araddr, 32'hBFC0_0100);
            end
        end
        check("sim_data_rdata", data_sram_rdata, 32'h7FFF_EFFF);
        check("sim_inst_rdata", inst_sram_rdata, 32'h403F_FEFF);
        cycle();
        inst_sram_en = 1'b0;
        data_sram_en = 1'b0;
        @(negedge clk);
        check("sim_release_stall", 32'(stallreq_for_axi), 32'd0);

        // Store: W accepted immediately, AW two cycles later, B after three WR_B cycles.
        aw_lat = 2;
        w_lat  = 0;
        b_lat  = 3;
        cycle();
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'b0011;
        data_sram_addr  = 32'h8000_2000;
        data_sram_wdata = 32'h1234_ABCD;
        @(negedge clk);
        check("wr_vec0", 32'({awvalid, wvalid, bready, stallreq_for_axi}), 32'(wr_vec[0]));
        for (int i = 1; i < 9; i++) begin
            cycle();
            @(negedge clk);
            check($sformatf("wr_vec%0d", i), 32'({awvalid, wvalid, bready, stallreq_for_axi}),
                  32'(wr_vec[i]));
            if (i == 1) begin
                check("wr_awid", 32'(awid), 32'd1);
                check("wr_awaddr", awaddr, 32'h8000_2000);
                check("wr_wstrb", 32'(wstrb), 32'h3);
                check("wr_wdata", wdata, 32'h1234_ABCD);
            end
        end
        cycle();
        data_sram_en  = 1'b0;
        data_sram_wen = 4'b0000;
        aw_lat        = 0;
        b_lat         = 0;
        @(negedge clk);
        check("wr_release_stall", 32'(stallreq_for_axi), 32'd0);

        // AR backpressure: arready held low for five cycles.
        ar_lat = 5;
        cycle();
        inst_sram_en   = 1'b1;
        inst_sram_addr = 32'hBFC0_0200;
        @(negedge clk);
        check("bp_vec0", 32'({arvalid, rready, stallreq_for_axi}), 32'(bp_vec[0]));
        for (int i = 1; i < 9; i++) begin
            cycle();
            @(negedge clk);
            check($sformatf("bp_vec%0d", i), 32'({arvalid, rready, stallreq_for_axi}),
                  32'(bp_vec[i]));
            if (i <= 6) begin
                check($sformatf("bp_araddr%0d", i), araddr, 32'hBFC0_0200);
                check($sformatf("bp_no_aw%0d", i), 32'(awvalid), 32'd0);
            end
        end
        check("bp_rdata", inst_sram_rdata, 32'h403F_FDFF);
        cycle();
        inst_sram_en = 1'b0;
        ar_lat       = 0;
        @(negedge clk);
        check("bp_release_stall", 32'(stallreq_for_axi), 32'd0);

        // Reset while waiting for R; the fetch must be reissued afterwards.
        r_lat = 3;
        cycle();
        inst_sram_en   = 1'b1;
        inst_sram_addr = 32'hBFC0_0300;
        @(negedge clk);
        check("rr_req_stall", 32'(stallreq_for_axi), 32'd1);
        cycle();
        @(negedge clk);
        check("rr_arvalid", 32'(arvalid), 32'd1);
        cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rr_in_rd_r", 32'(rready), 32'd1);
        check("rr_stall_in_rst", 32'(stallreq_for_axi), 32'd0);
        cycle();
        rst   = 1'b1;
        r_lat = 0;
        @(negedge clk);
        check("rr_after_rst_valids", 32'({arvalid, rready}), 32'd0);
        check("rr_after_rst_stall", 32'(stallreq_for_axi), 32'd1);
        check("rr_after_rst_inst_rdata", inst_sram_rdata, 32'd0);
        check("rr_after_rst_data_rdata", data_sram_rdata, 32'd0);
        cycle();
        @(negedge clk);
        check("rr_reissue_vec", 32'({arvalid, rready, stallreq_for_axi}), 32'b101);
        check("rr_reissue_araddr", araddr, 32'hBFC0_0300);
        cycle();
        @(negedge clk);
        check("rr_r_vec", 32'({arvalid, rready, stallreq_for_axi}), 32'b011);
        cycle();
        @(negedge clk);
        check("rr_done_stall", 32'(stallreq_for_axi), 32'd0);
        check("rr_rdata", inst_sram_rdata, 32'h403F_FCFF);
        cycle();
        inst_sram_en = 1'b0;
        @(negedge clk);
        check("rr_release_stall", 32'(stallreq_for_axi), 32'd0);

        // Total handshakes seen by the slave across the whole run.
        check("total_ar", 32'(n_ar), 32'd6);
        check("total_aw", 32'(n_aw), 32'd1);
        check("total_w", 32'(n_w), 32'd1);
        check("total_b", 32'(n_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_axi_arbiter.md
Name: sram_axi_arbiter

Overview:
- Shares one AXI3 master port between the core's instruction and data SRAM-style interfaces.
- Issues single-beat transfers with one transaction outstanding.
- Drives stallreq_for_axi into the core's CTRL stage until every request in the current core cycle has completed.
- Sits between mycpu_core and the SoC AXI crossbar; the top level ties off the AXI fields that are not listed below.

Parameters:
- INST_ID, 4'd0, arid driven for instruction fetches
- DATA_ID, 4'd1, arid/awid driven for data accesses
- ADDR_W, 32, address width (core and AXI)
- DATA_W, 32, data width; fixed 32 in this revision

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset (reset when rst==0)
- inst_sram_en  in  1  instruction request
- inst_sram_addr  in  ADDR_W  fetch address
- inst_sram_rdata  out  DATA_W  fetched word, registered
- data_sram_en  in  1  data request
- data_sram_wen  in  4  byte enables; 0 = read
- data_sram_addr  in  ADDR_W  data address
- data_sram_wdata  in  DATA_W  store data
- data_sram_rdata  out  DATA_W  load word, registered
- stallreq_for_axi  out  1  stall request to CTRL
- arid/araddr/arvalid  out  4/ADDR_W/1  AR channel
- arready  in  1  AR channel ready
- rdata/rvalid  in  DATA_W/1  R channel
- rready  out  1  R channel ready
- awid/awaddr/awvalid  out  4/ADDR_W/1  AW channel
- awready  in  1  AW channel ready
- wdata/wstrb/wvalid  out  DATA_W/4/1  W channel
- wready  in  1  W channel ready
- bvalid  in  1  B channel valid
- bready  out  1  B channel ready

Behaviour:
- Reset values (rst==0 at posedge):
  - state=IDLE.
  - All valid/ready outputs 0.
  - inst_done, data_done, aw_ok, w_ok cleared.
  - Both rdata registers 0.
- Reset mid-transaction abandons the transaction; the SoC resets the slave with the same rst.
- FSM states: IDLE, RD_AR, RD_R, WR_AW_W, WR_B.
- IDLE arbitration, in priority order:
  - data_sram_en & ~data_done → data access: RD_AR if wen==0, else WR_AW_W.
  - else inst_sram_en & ~inst_done → RD_AR with arid=INST_ID.
  - Data has priority over instruction fetch.
- Request latching: the address, wdata, wstrb and requester selected in IDLE are registered. AXI outputs come from these registers, never combinationally from core inputs.
- RD_AR:
  - arvalid=1, held stable until arready.
  - On arvalid & arready → RD_R.
- RD_R:
  - rready=1.
  - On rvalid: capture rdata into the selected requester's rdata register, set its done flag, go to IDLE.
- WR_AW_W:
  - awvalid=~aw_ok and wvalid=~w_ok, asserted concurrently.
  - Each handshake sets its ok flag.
  - Both may complete in the same cycle, in either order.
  - When both are complete (registered or current cycle) → WR_B and clear the ok flags.
- WR_B:
  - bready=1.
  - On bvalid: set data_done, go to IDLE. bresp is ignored.
- stallreq_for_axi (combinational) = (state!=IDLE) | (data_sram_en & ~data_done) | (inst_sram_en & ~inst_done).
  - It asserts in the same cycle a new request appears.
- Done flags clear at any posedge where stallreq_for_axi==0, i.e. when the core advances.
- The core holds en/addr/wen/wdata stable while stalled.
- Timing with both requests in one cycle: data completes, then inst; the stall drops the cycle after the inst R beat.
- Minimum latency, zero-wait slave:
  - Read: request cycle C (IDLE), arvalid in C+1, rvalid earliest C+2.
  - rdata visible and stall low in C+3.
- rdata registers hold their value until the next capture for the same requester.
- Timing rules:
  - No valid is ever dropped before its ready.
  - At most one AXI transaction is outstanding.
  - The block adds no combinational path from any AXI input to any AXI output.

Test Plan:
- Reset: rst=0 for 2 cycles with inst_sram_en=1 → all valids 0, stallreq_for_axi=1 only from the first cycle after reset releases, both rdata=0.
- Single fetch: inst_sram_en=1, addr=0xBFC00000, slave arready/rvalid immediate with rdata=0x3C1D8001 → arid=0, araddr=0xBFC00000, inst_sram_rdata=0x3C1D8001, stall low 3 cycles after the request.
- Simultaneous fetch plus load at 0x80001000 → data AR (arid=1) issued first, then inst AR; stall stays high until the inst R beat; the two rdata registers are correct and not swapped.
- Store wen=4'b0011, wdata=0x1234ABCD: slave gives wready two cycles before awready, then bvalid after 3 cycles → wstrb=0011, wvalid drops after its handshake, awvalid held until its handshake, bready=1 in WR_B, stall released the cycle after bvalid.
- Backpressure: arready low for 5 cycles → arvalid and araddr held constant throughout, no second request issued.
- Reset asserted in RD_R → next cycle IDLE, rready=0, done flags cleared, and the fetch is reissued after reset releases.
